// File: rtl/posit_extract_pipe_es3.sv
// Three-stage pipelined posit<32,3> decoder: word -> {sgn, scale, fraction, inf, zero}.
// Valid/ready handshake with full backpressure; bubbles collapse.
module posit_extract_pipe_es3 #(
    parameter int unsigned NBITS = 32,
    parameter int unsigned ES    = 3,
    parameter int unsigned SBITS = 9,
    parameter int unsigned FBITS = 27
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBITS-1:0]             in_posit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SBITS+FBITS+2:0]       out_value
);

    localparam int unsigned BW = NBITS - 1;
    localparam int unsigned IW = $clog2(BW);
    localparam int unsigned KW = $clog2(NBITS) + 1;
    localparam int unsigned RW = SBITS - ES;
    localparam int unsigned VW = 1 + SBITS + FBITS + 2;

    logic          s1_valid_q, s2_valid_q, s3_valid_q;
    logic          adv1, adv2, adv3;

    logic          s1_sgn_q, s1_zero_q, s1_inf_q;
    logic [BW-1:0] s1_body_q;
    logic [BW-1:0] s1_body_d;
    logic          s1_zero_d, s1_inf_d;
    logic [NBITS-1:0] neg_posit;

    logic          s2_sgn_q, s2_zero_q, s2_inf_q;
    logic [RW-1:0] s2_regime_q, s2_regime_d;
    logic [BW-1:0] s2_rem_q, s2_rem_d;
    logic [KW-1:0] run_len;
    logic          r0, in_run;

    logic [VW-1:0]    out_value_q, s3_value_d;
    logic [ES-1:0]    exp_f;
    logic [SBITS-1:0] scale;
    logic [FBITS-1:0] frac;

    // Advance chain: a stage loads when empty or when its successor loads/drains.
    assign adv3      = ~s3_valid_q | out_ready;
    assign adv2      = ~s2_valid_q | adv3;
    assign adv1      = ~s1_valid_q | adv2;
    assign in_ready  = adv1;
    assign out_valid = s3_valid_q;
    assign out_value = out_value_q;

    // S1: specials and sign-magnitude body.
    always_comb begin
        neg_posit = ~in_posit + NBITS'(1);
        s1_body_d = in_posit[NBITS-1] ? neg_posit[BW-1:0] : in_posit[BW-1:0];
        s1_zero_d = (in_posit == '0);
        s1_inf_d  = (in_posit == {1'b1, {BW{1'b0}}});
    end

    // S2: regime run length, regime value and remainder after the terminator.
    always_comb begin
        r0      = s1_body_q[BW-1];
        run_len = '0;
        in_run  = 1'b1;
        for (int i = BW - 1; i >= 0; i--) begin
            if (in_run && (s1_body_q[IW'(i)] == r0)) begin
                run_len = run_len + KW'(1);
            end else begin
                in_run = 1'b0;
            end
        end
        s2_regime_d = r0 ? RW'(run_len - KW'(1)) : RW'(KW'(0) - run_len);
        s2_rem_d    = s1_body_q << (run_len + KW'(1));
    end

    // S3: regime*8 + exp is just the concatenation since exp < 8.
    always_comb begin
        exp_f = s2_rem_q[BW-1 -: ES];
        scale = {s2_regime_q, exp_f};
        frac  = {1'b1, s2_rem_q[BW-1-ES -: FBITS-1]};
        if (s2_zero_q || s2_inf_q) begin
            s3_value_d = {{(VW-2){1'b0}}, s2_inf_q, s2_zero_q};
        end else begin
            s3_value_d = {s2_sgn_q, scale, frac, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s1_sgn_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_body_q   <= '0;
            s2_sgn_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_regime_q <= '0;
            s2_rem_q    <= '0;
            out_value_q <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sgn_q  <= in_posit[NBITS-1];
                    s1_zero_q <= s1_zero_d;
                    s1_inf_q  <= s1_inf_d;
                    s1_body_q <= s1_body_d;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_sgn_q    <= s1_sgn_q;
                    s2_zero_q   <= s1_zero_q;
                    s2_inf_q    <= s1_inf_q;
                    s2_regime_q <= s2_regime_d;
                    s2_rem_q    <= s2_rem_d;
                end
            end
            if (adv3) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    out_value_q <= s3_value_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_extract_pipe_es3.sv
// Directed + random bench for posit_extract_pipe_es3 with an in-order scoreboard.
module tb_posit_extract_pipe_es3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_posit;
    logic        out_valid;
    logic        out_ready;
    logic [38:0] out_value;

    posit_extract_pipe_es3 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          acc_cyc = -1;
    int          first_out_cyc = -1;
    int          out_seen = 0;
    int          stall_start = -100;
    logic        rand_ready = 1'b0;
    logic        accepted;
    logic        stalled_prev = 1'b0;
    logic        in_ready_low_seen;
    logic [38:0] held;
    logic [38:0] pend_exp;
    logic [38:0] sb[$];

    function automatic logic [38:0] mk(input logic s, input logic [8:0] sc, input logic [26:0] f,
                                       input logic i, input logic z);
        return {s, sc, f, i, z};
    endfunction

    // Bit-serial reference decode: walk the word from the MSB.
    function automatic logic [38:0] ref_decode(input logic [31:0] p);
        logic [31:0] a;
        logic        r0;
        int          i, k, regime, ex, fr, sc;
        if (p == 32'h0) return mk(1'b0, 9'h0, 27'h0, 1'b0, 1'b1);
        if (p == 32'h8000_0000) return mk(1'b0, 9'h0, 27'h0, 1'b1, 1'b0);
        a  = p[31] ? (~p + 32'd1) : p;
        r0 = a[30];
        i  = 30;
        k  = 0;
        while (i >= 0 && a[i] == r0) begin
            k++;
            i--;
        end
        i--;
        regime = r0 ? k - 1 : -k;
        ex = 0;
        for (int j = 0; j < 3; j++) begin
            ex = ex * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        fr = 1;
        for (int j = 0; j < 26; j++) begin
            fr = fr * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        sc = regime * 8 + ex;
        return mk(p[31], 9'(sc), 27'(fr), 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score transfers, then advance to posedge+1.
    task automatic cycle();
        @(negedge clk);
        accepted = 1'b0;
        if (!in_ready) in_ready_low_seen = 1'b1;
        if (stalled_prev) begin
            check("stall_valid", 39'(out_valid), 39'(1));
            check("stall_hold", out_value, held);
        end
        stalled_prev = out_valid && !out_ready;
        held = out_value;
        if (out_valid && out_ready) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            out_seen++;
            vec_cnt++;
            assert (sb.size() != 0) else begin
                err_cnt++;
                $error("FAIL spurious_out: observed %h expected none", out_value);
            end
            if (sb.size() != 0) check("out_value", out_value, sb.pop_front());
        end
        if (in_valid && in_ready) begin
            sb.push_back(pend_exp);
            accepted = 1'b1;
            if (acc_cyc < 0) acc_cyc = cyc;
        end
        if (reset) begin
            sb.delete();
            stalled_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        else            out_ready = !(cyc >= stall_start && cyc < stall_start + 5);
    endtask

    // Hold in_valid until accepted (bounded); leaves in_valid high for back-to-back use.
    task automatic send(input logic [31:0] p, input logic [38:0] e);
        int n = 0;
        in_valid = 1'b1;
        in_posit = p;
        pend_exp = e;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            cycle();
            n++;
        end
        vec_cnt++;
        assert (accepted) else begin
            err_cnt++;
            $error("FAIL accept_timeout: observed %0d cycles expected accept", n);
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check("drain_empty", 39'(sb.size()), 39'(0));
    endtask

    localparam logic [26:0] ONE = 27'h400_0000;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_posit  = '0;
        out_ready = 1'b1;
        pend_exp  = '0;
        in_ready_low_seen = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_out_valid", 39'(out_valid), 39'(0));
        check("rst_in_ready", 39'(in_ready), 39'(1));
        check("rst_out_value", out_value, 39'(0));

        // Directed single words with hand-derived expectations.
        send(32'h4000_0000, mk(1'b0, 9'd0, ONE, 1'b0, 1'b0));
        drain();
        check("latency", 39'(first_out_cyc - acc_cyc), 39'(3));
        send(32'hC000_0000, mk(1'b1, 9'd0, ONE, 1'b0, 1'b0));
        send(32'h4800_0000, mk(1'b0, 9'd2, ONE, 1'b0, 1'b0));
        send(32'h5000_0000, mk(1'b0, 9'd4, ONE, 1'b0, 1'b0));
        send(32'h7FFF_FFFF, mk(1'b0, 9'd240, ONE, 1'b0, 1'b0));
        send(32'h0000_0001, mk(1'b0, 9'h110, ONE, 1'b0, 1'b0));
        send(32'h8000_0001, mk(1'b1, 9'd240, ONE, 1'b0, 1'b0));
        send(32'h0000_0000, mk(1'b0, 9'd0, 27'h0, 1'b0, 1'b1));
        send(32'h8000_0000, mk(1'b0, 9'd0, 27'h0, 1'b1, 1'b0));
        send(32'h4000_0004, mk(1'b0, 9'd0, 27'h400_0004, 1'b0, 1'b0));
        send(32'h3000_0000, mk(1'b0, 9'h1FC, ONE, 1'b0, 1'b0));
        drain();

        // Back-to-back stream with a 5-cycle downstream stall.
        in_ready_low_seen = 1'b0;
        out_seen = 0;
        stall_start = cyc + 4;
        for (int w = 0; w < 8; w++) begin
            logic [31:0] p;
            p = $urandom();
            send(p, ref_decode(p));
        end
        drain();
        check("stall_in_ready_fell", 39'(in_ready_low_seen), 39'(1));
        check("stream_count", 39'(out_seen), 39'(8));

        // Random words with random backpressure.
        rand_ready = 1'b1;
        for (int w = 0; w < 24; w++) begin
            logic [31:0] p;
            p = $urandom();
            send(p, ref_decode(p));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Reset with two words in flight.
        send(32'h4800_0000, mk(1'b0, 9'd2, ONE, 1'b0, 1'b0));
        send(32'h5000_0000, mk(1'b0, 9'd4, ONE, 1'b0, 1'b0));
        in_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_out_valid", 39'(out_valid), 39'(0));
        check("midrst_out_value", out_value, 39'(0));
        out_seen = 0;
        for (int n = 0; n < 10; n++) cycle();
        check("midrst_no_stale", 39'(out_seen), 39'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
